ledm_gen: RTL and testbench
===========================

Name: ledm_gen

Overview:
Parametrised, multi-channel LED manager for communication and optical-module status indication; drives one run LED and CH_NUM bi-colour link LEDs.
- Per channel: stretches activity pulses, blinks red on link error, shows steady red when a link goes silent, and forces off when the slot or config is disabled.
- Sits beside the link receivers/transmitters on the comm board, fed by their eop/err strobes.
- Replaces fixed-count, 2-bit pass-through LED logic with per-channel hold, timeout and shared-phase blink.

Parameters:
CH_NUM, 10, number of bi-colour link LED channels (1..32)
TICK_DIV, 100000, clk_sys cycles per base tick (1 ms at 100 MHz); must be >= 2
HOLD_TICKS, 50, ticks green stays on after last eop (>= 1)
TIMEOUT_TICKS, 1000, ticks without eop before a channel is declared lost (> HOLD_TICKS)
BLINK_TICKS, 250, ticks per half-period of the shared blink phase (>= 1)

Ports:
clk_sys  in  1  system clock
rst_sys_n  in  1  reset; asynchronous, active-low
cfg_en  in  1  configuration valid; 0 forces all outputs off
self_cfg_err  in  1  self-config error; run LED blinks, all link LEDs forced 00
slot_en  in  CH_NUM  per-channel enable
link_eop  in  CH_NUM  per-channel activity pulse (1-cycle or level, counted as one event per cycle high)
link_err  in  CH_NUM  per-channel error level
lamp_test  in  1  lamp-test request (only with LEDM_LAMP_TEST_EN)
run_led  out  1  run LED
led_out  out  2*CH_NUM  channel i at [2i+1:2i]; 2'b01 green, 2'b10 red, 2'b00 off

Behaviour:
- Reset: run_led=0, led_out=all 0, tick counter=0, blink phase=0, all channels in OFF, all per-channel counters=0.
- Tick: counter runs 0..TICK_DIV-1 and wraps; tick pulses high for one cycle when count==TICK_DIV-1.
- Blink phase: toggles after every BLINK_TICKS ticks; shared by all channels and run_led so blinks stay in sync.
- run_led (registered):
  - cfg_en=0: 0.
  - cfg_en=1, self_cfg_err=0: 1.
  - cfg_en=1, self_cfg_err=1: equals blink phase.
- Channel FSM, one per channel, with per-channel hold and idle counters (ticks):
  - OFF: led 00. Entered from any state next cycle when cfg_en=0 or slot_en[i]=0. Leaves to IDLE when both are 1; idle counter cleared on entry.
  - IDLE: led 00. Idle counter increments on tick.
    - link_err -> ERR.
    - link_eop -> ACT.
    - idle counter reaches TIMEOUT_TICKS -> LOST.
  - ACT: led 01. Each eop reloads hold=HOLD_TICKS and clears idle counter. Hold decrements on tick (saturates at 0).
    - link_err -> ERR.
    - hold==0 -> IDLE; idle counter keeps counting from its last value.
  - ERR: led = blink phase ? 10 : 00.
    - Leaves to IDLE when link_err=0, with idle counter cleared.
  - LOST: led 10 steady.
    - link_eop -> ACT.
    - link_err -> ERR.
- Simultaneous events: disable > err > eop > timeout. An eop in the same cycle as err is ignored.
- Latency: input sampled at edge k; FSM state and led_out update at edge k+1 (led_out decoded from next state, registered).
- Counters are wide enough for their parameter (clog2 + 1) and saturate; no wrap-around.
- self_cfg_err=1 masks led_out to 0. The FSMs keep running underneath, so unmasking shows the current state on the next cycle.
- Asserting reset mid-operation returns everything to reset values immediately.

Optional Feature:
LEDM_LAMP_TEST_EN
- Defined: while lamp_test=1 and cfg_en=1, led_out shows all-green for one full blink half-period, then all-red for the next, alternating; run_led=1. The FSMs keep running. Release restores normal outputs on the next cycle.
- Undefined: lamp_test port still present but ignored; no lamp-test logic synthesised.

Test Plan:
Bench parameters for all scenarios: CH_NUM=4, TICK_DIV=4, HOLD_TICKS=3, TIMEOUT_TICKS=8, BLINK_TICKS=2.
1. Reset release, cfg_en=1, slot_en=4'hF, no eop -> led_out=0 until 8 ticks (32 cycles + 1), then each channel 2'b10 steady.
2. Single eop on ch1 at cycle k -> led_out[3:2]=01 at k+1; back to 00 after 3 ticks. Second eop inside the hold window extends green by a full 3 ticks.
3. link_err[2] high for 20 ticks -> led_out[5:4] toggles 10/00 every 2 ticks, in phase with run_led when self_cfg_err=1. Release -> 00, and LOST only after 8 further ticks.
4. eop and err asserted in the same cycle on ch0 -> ERR (blink red), never green. slot_en[0] dropped mid-ERR -> 00 next cycle.
5. self_cfg_err=1 with ch3 active -> led_out=0, run_led blinking. Release -> ch3 green next cycle. cfg_en=0 -> run_led=0 and all channels OFF.
6. With LEDM_LAMP_TEST_EN: lamp_test=1 -> all 01 for 8 cycles, then all 10 for 8 cycles, run_led=1. Without the macro: outputs unaffected.

Source files
------------

// File: rtl/ledm_gen.sv
// ledm_gen: multi-channel LED manager for link and optical-module status.
// Drives one run LED and CH_NUM bi-colour link LEDs (01 green, 10 red, 00 off).
// All timing is counted in base ticks of TICK_DIV clk_sys cycles. One blink phase
// is shared by every channel and by run_led, so all blinking LEDs stay in step.
// Optional lamp test: define LEDM_LAMP_TEST_EN to enable it. Without the macro
// the lamp_test input is ignored.
//
// Channel FSM states:
//   state   | meaning
//   ST_OFF  | slot or configuration disabled, LED off
//   ST_IDLE | enabled with no recent activity, LED off, idle timer running
//   ST_ACT  | activity seen within the hold window, LED green
//   ST_ERR  | link error present, LED blinks red
//   ST_LOST | no activity for TIMEOUT_TICKS, LED steady red

module ledm_gen #(
    parameter int CH_NUM        = 10,
    parameter int TICK_DIV      = 100000,
    parameter int HOLD_TICKS    = 50,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int BLINK_TICKS   = 250
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys_n,
    input  logic                  cfg_en,
    input  logic                  self_cfg_err,
    input  logic [CH_NUM-1:0]     slot_en,
    input  logic [CH_NUM-1:0]     link_eop,
    input  logic [CH_NUM-1:0]     link_err,
    input  logic                  lamp_test,
    output logic                  run_led,
    output logic [2*CH_NUM-1:0]   led_out
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(HOLD_TICKS) + 1;
    localparam int IDLE_W = $clog2(TIMEOUT_TICKS) + 1;
    localparam int BLNK_W = $clog2(BLINK_TICKS) + 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_TICKS);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_TICKS);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = '1;
    localparam logic [BLNK_W-1:0] BLNK_LAST  = BLNK_W'(BLINK_TICKS - 1);

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_IDLE = 3'd1,
        ST_ACT  = 3'd2,
        ST_ERR  = 3'd3,
        ST_LOST = 3'd4
    } ch_state_e;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [BLNK_W-1:0] blink_cnt;
    logic              blink_q;
    logic              blink_wrap;
    logic              blink_nxt;
    logic              lamp_on;
    logic              lamp_ph;

    assign tick       = (tick_cnt == TICK_LAST);
    assign blink_wrap = tick && (blink_cnt == BLNK_LAST);
    assign blink_nxt  = blink_q ^ blink_wrap;

    // Free-running base tick divider, 0..TICK_DIV-1.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Shared blink phase, toggled after every BLINK_TICKS ticks.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else begin
            blink_q <= blink_nxt;
            if (blink_wrap) begin
                blink_cnt <= '0;
            end else if (tick) begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

`ifdef LEDM_LAMP_TEST_EN
    localparam int LAMP_HALF = BLINK_TICKS * TICK_DIV;
    localparam int LAMP_W    = $clog2(LAMP_HALF);
    localparam logic [LAMP_W-1:0] LAMP_LAST = LAMP_W'(LAMP_HALF - 1);

    logic [LAMP_W-1:0] lamp_cnt;

    assign lamp_on = lamp_test & cfg_en;

    // Lamp-test phase restarts on every request so green always shows a full half-period first.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            lamp_cnt <= '0;
            lamp_ph  <= 1'b0;
        end else if (!lamp_on) begin
            lamp_cnt <= '0;
            lamp_ph  <= 1'b0;
        end else if (lamp_cnt == LAMP_LAST) begin
            lamp_cnt <= '0;
            lamp_ph  <= ~lamp_ph;
        end else begin
            lamp_cnt <= lamp_cnt + 1'b1;
        end
    end
`else
    logic lamp_test_unused;

    assign lamp_test_unused = lamp_test;
    assign lamp_on          = 1'b0;
    assign lamp_ph          = 1'b0;
`endif

    // Run LED: off when unconfigured, blinking on self-config error, otherwise steady on.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            run_led <= 1'b0;
        end else if (!cfg_en) begin
            run_led <= 1'b0;
        end else if (lamp_on) begin
            run_led <= 1'b1;
        end else if (self_cfg_err) begin
            run_led <= blink_nxt;
        end else begin
            run_led <= 1'b1;
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        ch_state_e         st_q;
        ch_state_e         st_nxt;
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_nxt;
        logic [HOLD_W-1:0] hold_dec;
        logic [IDLE_W-1:0] idle_q;
        logic [IDLE_W-1:0] idle_nxt;
        logic [IDLE_W-1:0] idle_inc;
        logic [1:0]        led_q;
        logic [1:0]        led_nxt;
        logic              en_i;
        logic              eop_i;
        logic              err_i;

        assign en_i     = cfg_en & slot_en[i];
        assign eop_i    = link_eop[i];
        assign err_i    = link_err[i];
        assign hold_dec = (tick && (hold_q != '0)) ? hold_q - 1'b1 : hold_q;
        assign idle_inc = (tick && (idle_q != IDLE_MAX)) ? idle_q + 1'b1 : idle_q;

        // Next-state and timer update; priority is disable > err > eop > timeout.
        always_comb begin
            st_nxt   = st_q;
            hold_nxt = hold_q;
            idle_nxt = idle_q;
            if (!en_i) begin
                st_nxt   = ST_OFF;
                hold_nxt = '0;
                idle_nxt = '0;
            end else begin
                case (st_q)
                    ST_OFF: begin
                        st_nxt   = ST_IDLE;
                        hold_nxt = '0;
                        idle_nxt = '0;
                    end
                    ST_IDLE: begin
                        if (err_i) begin
                            st_nxt   = ST_ERR;
                            idle_nxt = '0;
                        end else if (eop_i) begin
                            st_nxt   = ST_ACT;
                            hold_nxt = HOLD_LOAD;
                            idle_nxt = '0;
                        end else begin
                            idle_nxt = idle_inc;
                            if (idle_inc >= IDLE_LIMIT) begin
                                st_nxt = ST_LOST;
                            end
                        end
                    end
                    ST_ACT: begin
                        if (err_i) begin
                            st_nxt   = ST_ERR;
                            hold_nxt = '0;
                            idle_nxt = '0;
                        end else if (eop_i) begin
                            hold_nxt = HOLD_LOAD;
                            idle_nxt = '0;
                        end else begin
                            hold_nxt = hold_dec;
                            idle_nxt = idle_inc;
                            if (hold_dec == '0) begin
                                st_nxt = ST_IDLE;
                            end
                        end
                    end
                    ST_ERR: begin
                        hold_nxt = '0;
                        idle_nxt = '0;
                        if (!err_i) begin
                            st_nxt = ST_IDLE;
                        end
                    end
                    ST_LOST: begin
                        if (err_i) begin
                            st_nxt   = ST_ERR;
                            idle_nxt = '0;
                        end else if (eop_i) begin
                            st_nxt   = ST_ACT;
                            hold_nxt = HOLD_LOAD;
                            idle_nxt = '0;
                        end
                    end
                    default: begin
                        st_nxt   = ST_OFF;
                        hold_nxt = '0;
                        idle_nxt = '0;
                    end
                endcase
            end
        end

        // LED colour decoded from the next state so it lands with the state change.
        always_comb begin
            led_nxt = 2'b00;
            if (lamp_on) begin
                led_nxt = lamp_ph ? 2'b10 : 2'b01;
            end else if (!self_cfg_err) begin
                case (st_nxt)
                    ST_ACT:  led_nxt = 2'b01;
                    ST_ERR:  led_nxt = blink_nxt ? 2'b10 : 2'b00;
                    ST_LOST: led_nxt = 2'b10;
                    default: led_nxt = 2'b00;
                endcase
            end
        end

        // Channel state, timers and registered LED output.
        always_ff @(posedge clk_sys or negedge rst_sys_n) begin
            if (!rst_sys_n) begin
                st_q   <= ST_OFF;
                hold_q <= '0;
                idle_q <= '0;
                led_q  <= 2'b00;
            end else begin
                st_q   <= st_nxt;
                hold_q <= hold_nxt;
                idle_q <= idle_nxt;
                led_q  <= led_nxt;
            end
        end

        assign led_out[2*i +: 2] = led_q;
    end

endmodule

// File: tb/tb_ledm_gen.sv
// Directed self-checking bench for ledm_gen with CH_NUM=4, TICK_DIV=4,
// HOLD_TICKS=3, TIMEOUT_TICKS=8, BLINK_TICKS=2.
// Edge e is the e-th rising clock edge after reset release; ticks are consumed
// on edges that are multiples of 4 and the blink phase is 1 on edges 8..15, 24..31, ...

module tb_ledm_gen;

    logic       clk_sys      = 1'b0;
    logic       rst_sys_n    = 1'b1;
    logic       cfg_en       = 1'b0;
    logic       self_cfg_err = 1'b0;
    logic       lamp_test    = 1'b0;
    logic [3:0] slot_en      = 4'h0;
    logic [3:0] link_eop     = 4'h0;
    logic [3:0] link_err     = 4'h0;
    logic       run_led;
    logic [7:0] led_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk_sys = ~clk_sys;

    ledm_gen #(
        .CH_NUM        (4),
        .TICK_DIV      (4),
        .HOLD_TICKS    (3),
        .TIMEOUT_TICKS (8),
        .BLINK_TICKS   (2)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_sys_n    (rst_sys_n),
        .cfg_en       (cfg_en),
        .self_cfg_err (self_cfg_err),
        .slot_en      (slot_en),
        .link_eop     (link_eop),
        .link_err     (link_err),
        .lamp_test    (lamp_test),
        .run_led      (run_led),
        .led_out      (led_out)
    );

    task automatic step_to(input int e);
        while (cyc < e) begin
            @(posedge clk_sys);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst_sys_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        rst_sys_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        #1 rst_sys_n = 1'b0;
        #3;
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_led: led_out=%h expected 00", led_out);
        end
        n_cmp++;
        if (run_led !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_run: run_led=%b expected 0", run_led);
        end
        cfg_en  = 1'b1;
        slot_en = 4'hF;
        do_reset();
        step_to(1);
        n_cmp++;
        if (run_led !== 1'b1) begin
            n_bad++;
            $display("FAIL release_run: run_led=%b expected 1", run_led);
        end
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL release_led: led_out=%h expected 00", led_out);
        end
    endtask

    task automatic test_timeout();
        cfg_en = 1'b1; slot_en = 4'hF; link_eop = 4'h0; link_err = 4'h0;
        do_reset();
        step_to(31);
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL timeout_before: led_out=%h expected 00", led_out);
        end
        step_to(32);
        n_cmp++;
        if (led_out !== 8'hAA) begin
            n_bad++;
            $display("FAIL timeout_lost: led_out=%h expected aa", led_out);
        end
    endtask

    task automatic test_activity();
        int         e_tab[7] = '{15, 16, 18, 28, 31, 32, 51};
        logic [7:0] x_tab[7] = '{8'h04, 8'h00, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00};
        cfg_en = 1'b1; slot_en = 4'h2; link_eop = 4'h0; link_err = 4'h0;
        do_reset();
        step_to(5);
        link_eop = 4'h2;
        step_to(6);
        link_eop = 4'h0;
        n_cmp++;
        if (led_out !== 8'h04) begin
            n_bad++;
            $display("FAIL act_on: led_out=%h expected 04", led_out);
        end
        for (int k = 0; k < 7; k++) begin
            step_to(e_tab[k]);
            if (e_tab[k] == 18) link_eop = 4'h0;
            n_cmp++;
            if (led_out !== x_tab[k]) begin
                n_bad++;
                $display("FAIL act_edge%0d: led_out=%h expected %h", e_tab[k], led_out, x_tab[k]);
            end
            if (e_tab[k] == 16) begin
                step_to(17);
                link_eop = 4'h2;
            end
            if (e_tab[k] == 18) begin
                step_to(21);
                link_eop = 4'h2;
                step_to(22);
                link_eop = 4'h0;
            end
        end
        step_to(52);
        n_cmp++;
        if (led_out !== 8'h08) begin
            n_bad++;
            $display("FAIL act_then_lost: led_out=%h expected 08", led_out);
        end
    endtask

    task automatic test_error();
        cfg_en = 1'b1; slot_en = 4'h4; link_eop = 4'h0; link_err = 4'h4; self_cfg_err = 1'b0;
        do_reset();
        step_to(7);
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL err_ph0: led_out=%h expected 00", led_out);
        end
        step_to(8);
        n_cmp++;
        if (led_out !== 8'h20) begin
            n_bad++;
            $display("FAIL err_ph1: led_out=%h expected 20", led_out);
        end
        step_to(16);
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL err_ph0b: led_out=%h expected 00", led_out);
        end
        step_to(41);
        self_cfg_err = 1'b1;
        step_to(42);
        n_cmp++;
        if (run_led !== 1'b1 || led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL err_mask_ph1: run_led=%b led_out=%h expected 1 00", run_led, led_out);
        end
        step_to(44);
        self_cfg_err = 1'b0;
        step_to(45);
        n_cmp++;
        if (run_led !== 1'b1 || led_out !== 8'h20) begin
            n_bad++;
            $display("FAIL err_unmask: run_led=%b led_out=%h expected 1 20", run_led, led_out);
        end
        step_to(50);
        self_cfg_err = 1'b1;
        step_to(51);
        n_cmp++;
        if (run_led !== 1'b0 || led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL err_mask_ph0: run_led=%b led_out=%h expected 0 00", run_led, led_out);
        end
        step_to(56);
        n_cmp++;
        if (run_led !== 1'b1) begin
            n_bad++;
            $display("FAIL err_run_toggle: run_led=%b expected 1", run_led);
        end
        self_cfg_err = 1'b0;
        step_to(57);
        n_cmp++;
        if (led_out !== 8'h20) begin
            n_bad++;
            $display("FAIL err_ph1c: led_out=%h expected 20", led_out);
        end
        step_to(80);
        link_err = 4'h0;
        step_to(81);
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL err_release: led_out=%h expected 00", led_out);
        end
        step_to(111);
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL err_not_lost_yet: led_out=%h expected 00", led_out);
        end
        step_to(112);
        n_cmp++;
        if (led_out !== 8'h20) begin
            n_bad++;
            $display("FAIL err_then_lost: led_out=%h expected 20", led_out);
        end
    endtask

    task automatic test_err_priority();
        cfg_en = 1'b1; slot_en = 4'hF; link_eop = 4'h0; link_err = 4'h0; self_cfg_err = 1'b0;
        do_reset();
        step_to(2);
        link_eop = 4'h1;
        link_err = 4'h1;
        step_to(3);
        link_eop = 4'h0;
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL prio_no_green: led_out=%h expected 00", led_out);
        end
        step_to(8);
        n_cmp++;
        if (led_out !== 8'h02) begin
            n_bad++;
            $display("FAIL prio_err_blink: led_out=%h expected 02", led_out);
        end
        step_to(9);
        slot_en = 4'hE;
        step_to(10);
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL prio_slot_off: led_out=%h expected 00", led_out);
        end
        step_to(32);
        n_cmp++;
        if (led_out !== 8'hA8) begin
            n_bad++;
            $display("FAIL prio_others_lost: led_out=%h expected a8", led_out);
        end
        link_err = 4'h0;
    endtask

    task automatic test_self_cfg();
        cfg_en = 1'b1; slot_en = 4'h8; link_eop = 4'h8; link_err = 4'h0; self_cfg_err = 1'b0;
        do_reset();
        step_to(2);
        n_cmp++;
        if (led_out !== 8'h40 || run_led !== 1'b1) begin
            n_bad++;
            $display("FAIL self_act: led_out=%h run_led=%b expected 40 1", led_out, run_led);
        end
        step_to(3);
        self_cfg_err = 1'b1;
        step_to(4);
        n_cmp++;
        if (led_out !== 8'h00 || run_led !== 1'b0) begin
            n_bad++;
            $display("FAIL self_mask: led_out=%h run_led=%b expected 00 0", led_out, run_led);
        end
        step_to(8);
        n_cmp++;
        if (led_out !== 8'h00 || run_led !== 1'b1) begin
            n_bad++;
            $display("FAIL self_blink: led_out=%h run_led=%b expected 00 1", led_out, run_led);
        end
        step_to(9);
        self_cfg_err = 1'b0;
        step_to(10);
        n_cmp++;
        if (led_out !== 8'h40 || run_led !== 1'b1) begin
            n_bad++;
            $display("FAIL self_release: led_out=%h run_led=%b expected 40 1", led_out, run_led);
        end
        step_to(12);
        cfg_en = 1'b0;
        step_to(13);
        n_cmp++;
        if (led_out !== 8'h00 || run_led !== 1'b0) begin
            n_bad++;
            $display("FAIL cfg_off: led_out=%h run_led=%b expected 00 0", led_out, run_led);
        end
        step_to(14);
        cfg_en = 1'b1;
        step_to(15);
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL cfg_on_idle: led_out=%h expected 00", led_out);
        end
        step_to(16);
        n_cmp++;
        if (led_out !== 8'h40) begin
            n_bad++;
            $display("FAIL cfg_on_act: led_out=%h expected 40", led_out);
        end
        link_eop = 4'h0;
    endtask

    task automatic test_async_reset();
        cfg_en = 1'b1; slot_en = 4'h1; link_eop = 4'h1; link_err = 4'h0; self_cfg_err = 1'b0;
        do_reset();
        step_to(3);
        n_cmp++;
        if (led_out !== 8'h01) begin
            n_bad++;
            $display("FAIL areset_pre: led_out=%h expected 01", led_out);
        end
        #2 rst_sys_n = 1'b0;
        #1;
        n_cmp++;
        if (led_out !== 8'h00 || run_led !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_now: led_out=%h run_led=%b expected 00 0", led_out, run_led);
        end
        link_eop = 4'h0;
    endtask

    task automatic test_lamp();
        int         e_tab[5] = '{2, 9, 10, 17, 18};
`ifdef LEDM_LAMP_TEST_EN
        logic [7:0] x_tab[5] = '{8'h55, 8'h55, 8'hAA, 8'hAA, 8'h00};
`else
        logic [7:0] x_tab[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        cfg_en = 1'b1; slot_en = 4'hF; link_eop = 4'h0; link_err = 4'h0; self_cfg_err = 1'b0;
        do_reset();
        step_to(1);
        lamp_test = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step_to(e_tab[k]);
            n_cmp++;
            if (led_out !== x_tab[k] || run_led !== 1'b1) begin
                n_bad++;
                $display("FAIL lamp_edge%0d: led_out=%h run_led=%b expected %h 1",
                         e_tab[k], led_out, run_led, x_tab[k]);
            end
            if (e_tab[k] == 17) lamp_test = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_activity();
        test_error();
        test_err_priority();
        test_self_cfg();
        test_async_reset();
        test_lamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
